uart_encoder: RTL and testbench

//  Transmit-side counterpart of the UART command decoder. Serialises readback frames (ADC channels, ctrl-reg

---
 rtl/uart_encoder_pkg.sv | 39 +++
 rtl/uart_encoder_word_splitter.sv | 41 ++++
 rtl/uart_encoder.sv | 173 +++++++++++++++++
 tb/tb_uart_encoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_encoder_pkg.sv
// Shared definitions for the UART readback encoder: frame ids, byte flags,
// FSM state encoding and byte-building helpers.
// The trailer state exists only when UART_ENCODER_CHECKSUM_EN is defined.
package uart_encoder_pkg;

  // Framing ids understood by the host (the upper three bits are always zero on the wire)
  localparam logic [4:0] FRAME_MON      = 5'h0F;
  localparam logic [4:0] FRAME_P1_CH1   = 5'h10;
  localparam logic [4:0] FRAME_TSTAMP   = 5'h1F;

  // Command ids reserved by the matching receive-side decoder
  localparam logic [4:0] CMD_RSVD_FIRST = 5'h00;
  localparam logic [4:0] CMD_RSVD_LAST  = 5'h08;

  // Data bytes carry a set MSB so the host can tell them apart from framing bytes
  localparam logic       DATA_FLAG      = 1'b1;
  localparam int         CHUNK_W        = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_FETCH   = 3'd2,
    ST_WAIT_RD = 3'd3,
    ST_SEND    = 3'd4,
`ifdef UART_ENCODER_CHECKSUM_EN
    ST_CHKSUM  = 3'd5,
`endif
    ST_DONE    = 3'd6
  } enc_state_e;

  function automatic logic [7:0] header_byte(input logic [4:0] id);
    return {3'b000, id};
  endfunction

  function automatic logic [7:0] data_byte(input logic [CHUNK_W-1:0] payload);
    return {DATA_FLAG, payload};
  endfunction

endpackage

// File: rtl/uart_encoder_word_splitter.sv
// Holds one readback word and presents it as 7-bit chunks, most significant
// chunk first; last_chunk flags the final chunk of the word.
module uart_word_splitter
  import uart_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word_in,
  input  logic                  shift,
  output logic [CHUNK_W-1:0]    chunk,
  output logic                  last_chunk
);

  localparam int              BPW      = DATA_WIDTH / CHUNK_W;
  localparam int              CNT_W    = $clog2(BPW + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BPW - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      cnt;

  // Load a fresh word, or move the next chunk up into the top bits after each byte is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= word_in;
      cnt   <= '0;
    end else if (shift) begin
      shreg <= shreg << CHUNK_W;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  assign chunk      = shreg[DATA_WIDTH-1 -: CHUNK_W];
  assign last_chunk = (cnt == LAST_IDX);

endmodule

// File: rtl/uart_encoder.sv
// UART readback frame encoder: sends a framing byte, then every RAM word of the
// frame as DATA_WIDTH/7 flagged 7-bit bytes, paced by the UART TX handshake.
// Optional feature macro: UART_ENCODER_CHECKSUM_EN appends an XOR trailer byte.
module uart_encoder
  import uart_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_req,
  input  logic [4:0]            frame_id,
  input  logic [ADDR_WIDTH-1:0] frame_len,
  output logic                  frame_ack,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_ld,
  input  logic                  tx_busy,
  input  logic                  tx_pause
);

  localparam logic [ADDR_WIDTH:0] IDX_ONE = (ADDR_WIDTH + 1)'(1);
`ifdef UART_ENCODER_CHECKSUM_EN
  localparam enc_state_e AFTER_DATA = ST_CHKSUM;
`else
  localparam enc_state_e AFTER_DATA = ST_DONE;
`endif

  enc_state_e            state, next_state;
  logic [4:0]            id_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH:0]   word_idx, word_idx_next;
  logic                  accept, issue_ok, load_word, shift_chunk, last_chunk;
  logic [CHUNK_W-1:0]    chunk;
  logic                  tx_ld_next, frame_ack_next, frame_done_next, busy_next;
  logic [7:0]            tx_data_next;
`ifdef UART_ENCODER_CHECKSUM_EN
  logic [CHUNK_W-1:0]    csum_q, csum_next;
`endif

  uart_word_splitter #(.DATA_WIDTH(DATA_WIDTH)) u_splitter (
    .clk        (clk),
    .rst        (rst),
    .load       (load_word),
    .word_in    (rd_data),
    .shift      (shift_chunk),
    .chunk      (chunk),
    .last_chunk (last_chunk)
  );

  assign rd_addr = word_idx[ADDR_WIDTH-1:0];

  // Next-state and next-output logic; a byte is only issued when the UART is idle,
  // the host is not pausing us and no load strobe went out in the current cycle
  always_comb begin
    next_state      = state;
    word_idx_next   = word_idx;
    tx_ld_next      = 1'b0;
    tx_data_next    = tx_data;
    frame_ack_next  = 1'b0;
    frame_done_next = 1'b0;
    busy_next       = busy;
    load_word       = 1'b0;
    shift_chunk     = 1'b0;
    rd_en           = 1'b0;
    accept          = 1'b0;
    issue_ok        = !tx_busy && !tx_pause && !tx_ld;
`ifdef UART_ENCODER_CHECKSUM_EN
    csum_next       = csum_q;
`endif
    case (state)
      ST_IDLE: begin
        busy_next = 1'b0;
        if (frame_req && !busy) begin
          accept         = 1'b1;
          next_state     = ST_HEADER;
          frame_ack_next = 1'b1;
          busy_next      = 1'b1;
          word_idx_next  = '0;
`ifdef UART_ENCODER_CHECKSUM_EN
          csum_next      = '0;
`endif
        end
      end
      ST_HEADER: begin
        if (issue_ok) begin
          tx_ld_next   = 1'b1;
          tx_data_next = header_byte(id_q);
          next_state   = (len_q == '0) ? AFTER_DATA : ST_FETCH;
        end
      end
      ST_FETCH: begin
        rd_en      = 1'b1;
        next_state = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        load_word  = 1'b1;
        next_state = ST_SEND;
      end
      ST_SEND: begin
        if (issue_ok) begin
          tx_ld_next   = 1'b1;
          tx_data_next = data_byte(chunk);
          shift_chunk  = 1'b1;
`ifdef UART_ENCODER_CHECKSUM_EN
          csum_next    = csum_q ^ chunk;
`endif
          if (last_chunk) begin
            if ((word_idx + IDX_ONE) < {1'b0, len_q}) begin
              word_idx_next = word_idx + IDX_ONE;
              next_state    = ST_FETCH;
            end else begin
              next_state = AFTER_DATA;
            end
          end
        end
      end
`ifdef UART_ENCODER_CHECKSUM_EN
      ST_CHKSUM: begin
        if (issue_ok) begin
          tx_ld_next   = 1'b1;
          tx_data_next = data_byte(csum_q);
          next_state   = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        frame_done_next = 1'b1;
        next_state      = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State, frame parameters and registered outputs; reset drops any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      id_q       <= '0;
      len_q      <= '0;
      word_idx   <= '0;
      frame_ack  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      tx_ld      <= 1'b0;
      tx_data    <= '0;
`ifdef UART_ENCODER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state      <= next_state;
      word_idx   <= word_idx_next;
      frame_ack  <= frame_ack_next;
      frame_done <= frame_done_next;
      busy       <= busy_next;
      tx_ld      <= tx_ld_next;
      tx_data    <= tx_data_next;
`ifdef UART_ENCODER_CHECKSUM_EN
      csum_q     <= csum_next;
`endif
      if (accept) begin
        id_q  <= frame_id;
        len_q <= frame_len;
      end
    end
  end

endmodule

// File: tb/tb_uart_encoder.sv
// Scoreboard bench for uart_encoder: stimulus pushes the expected byte stream,
// a negedge monitor pops and compares on every tx_ld and checks the handshake.
`timescale 1ns/1ps
module tb_uart_encoder;

  localparam int DW  = 14;
  localparam int AW  = 10;
  localparam int BPW = DW / 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_req;
  logic [4:0]    frame_id;
  logic [AW-1:0] frame_len;
  logic          frame_ack, busy, frame_done, rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [7:0]    tx_data;
  logic          tx_ld, tx_busy, tx_pause;

  int tests = 0;
  int fails = 0;
  logic [7:0]    exp_q[$];
  logic [DW-1:0] ram [0:(1<<AW)-1];
  int ack_count = 0, done_count = 0, ld_count = 0, rd_count = 0;
  int exp_addr = 0, cur_len = 0, expected_acks = 0, expected_dones = 0;
  int busy_cnt = 0;
  logic prev_ld = 1'b0, prev_busy = 1'b0, prev_pause = 1'b0;
  bit rand_pause = 1'b0;

  uart_encoder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_req  (frame_req),
    .frame_id   (frame_id),
    .frame_len  (frame_len),
    .frame_ack  (frame_ack),
    .busy       (busy),
    .frame_done (frame_done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .tx_data    (tx_data),
    .tx_ld      (tx_ld),
    .tx_busy    (tx_busy),
    .tx_pause   (tx_pause)
  );

  always #5 clk = ~clk;

  // RAM answers one cycle after rd_en; junk otherwise
  always @(posedge clk) begin
    if (rd_en) rd_data <= ram[rd_addr];
    else       rd_data <= DW'($urandom);
  end

  // UART TX: busy from the cycle after tx_ld for 10 cycles
  always @(posedge clk) begin
    if (tx_ld)             busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Random host XOFF during the randomised phase
  always @(posedge clk) begin
    if (rand_pause) begin
      #1;
      tx_pause = ($urandom_range(0, 3) == 0);
    end
  end

  function automatic void checkOutput(string name, int actual, int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endfunction

  // Reference stream: header, then each word split MS 7 bits first, then optional XOR trailer
  task automatic pushExpected(input logic [4:0] id, input int len);
    int x, w, c;
    x = 0;
    exp_q.push_back({3'b000, id});
    for (int i = 0; i < len; i++) begin
      w = int'(ram[i]);
      for (int k = BPW - 1; k >= 0; k--) begin
        c = (w >> (7 * k)) & 127;
        exp_q.push_back(8'(128 + c));
        x = x ^ c;
      end
    end
`ifdef UART_ENCODER_CHECKSUM_EN
    exp_q.push_back(8'(128 + x));
`endif
  endtask

  // Monitor: scoreboard pop on every byte, plus handshake rules
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_ld) begin
        ld_count++;
        checkOutput("issue_rule", int'({prev_ld, prev_busy, prev_pause}), 0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", tx_data);
        end else begin
          checkOutput("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
        end
      end
      if (frame_done) begin
        done_count++;
        checkOutput("done_after_last_ld", int'(prev_ld), 1);
        checkOutput("queue_empty_at_done", exp_q.size(), 0);
      end
      if (frame_ack) begin
        ack_count++;
        checkOutput("busy_with_ack", int'(busy), 1);
      end
      if (rd_en) begin
        rd_count++;
        checkOutput("rd_addr", int'(rd_addr), exp_addr);
        checkOutput("rd_in_range", int'(exp_addr < cur_len), 1);
        exp_addr++;
      end
    end
    prev_ld    = tx_ld;
    prev_busy  = tx_busy;
    prev_pause = tx_pause;
  end

  task automatic applyStimulus(input logic [4:0] id, input int len);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    pushExpected(id, len);
    exp_addr = 0;
    cur_len  = len;
    @(posedge clk); #1;
    frame_id  = id;
    frame_len = AW'(len);
    frame_req = 1'b1;
    @(posedge clk); #1;
    frame_req = 1'b0;
    frame_id  = 5'($urandom);
    frame_len = AW'($urandom);
    @(negedge clk);
    checkOutput("frame_ack_pulse", int'(frame_ack), 1);
    expected_acks++;
    expected_dones++;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (done_count < expected_dones && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frame_done_count", done_count, expected_dones);
    repeat (2) @(negedge clk);
    checkOutput("busy_released", int'(busy), 0);
    checkOutput("ack_count", ack_count, expected_acks);
  endtask

  task automatic waitBytes(input int target);
    int n;
    n = 0;
    while (ld_count < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bytes_reached", int'(ld_count >= target), 1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_tx_ld"},      int'(tx_ld), 0);
    checkOutput({tag, "_tx_data"},    int'(tx_data), 0);
    checkOutput({tag, "_busy"},       int'(busy), 0);
    checkOutput({tag, "_frame_ack"},  int'(frame_ack), 0);
    checkOutput({tag, "_frame_done"}, int'(frame_done), 0);
    checkOutput({tag, "_rd_en"},      int'(rd_en), 0);
    checkOutput({tag, "_rd_addr"},    int'(rd_addr), 0);
  endtask

  initial begin
    int base, base_done, len;
    rst = 1'b1; frame_req = 1'b0; frame_id = '0; frame_len = '0; tx_pause = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Two-word frame from the reference example
    ram[0] = 14'h2A55; ram[1] = 14'h0001;
    applyStimulus(5'h10, 2);
    waitDone(2000);

    // Header-only frame must not touch the RAM
    base = rd_count;
    applyStimulus(5'h1B, 0);
    waitDone(2000);
    checkOutput("no_rd_on_empty", rd_count - base, 0);

    // Host pause after the second byte
    base = ld_count;
    applyStimulus(5'h10, 2);
    waitBytes(base + 2);
    @(posedge clk); #1 tx_pause = 1'b1;
    base = ld_count;
    repeat (50) @(posedge clk);
    #1 tx_pause = 1'b0;
    checkOutput("no_ld_during_pause", ld_count - base, 0);
    waitDone(2000);

    // Request while busy is dropped
    for (int i = 0; i < 3; i++) ram[i] = DW'($urandom);
    applyStimulus(5'h12, 3);
    repeat (15) @(posedge clk);
    #1 frame_req = 1'b1; frame_id = 5'h13; frame_len = AW'(1);
    @(posedge clk); #1 frame_req = 1'b0;
    @(negedge clk);
    checkOutput("ack_ignored_while_busy", int'(frame_ack), 0);
    waitDone(3000);

    // Reset mid-frame aborts silently, then a clean frame follows
    base = ld_count;
    applyStimulus(5'h14, 3);
    waitBytes(base + 2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkAllZero("abort");
    exp_q.delete();
    expected_dones--;
    base_done = done_count;
    repeat (30) @(negedge clk);
    checkOutput("no_done_after_abort", done_count, base_done);
    ram[0] = DW'($urandom);
    applyStimulus(5'h1F, 1);
    waitDone(2000);

    // Randomised frames with random host pauses
    rand_pause = 1'b1;
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) ram[i] = DW'($urandom);
      applyStimulus(5'($urandom_range(15, 31)), len);
      waitDone(4000);
    end
    rand_pause = 1'b0;
    @(posedge clk); #2 tx_pause = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails + 1);
    $fatal(1, "[TB] watchdog");
  end

endmodule
